// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth UART transmit queue: sequencer states and default sizing.
package bt_pkg;

    localparam int unsigned DEF_DEPTH       = 16;
    localparam int unsigned DEF_ADDR_W      = 4;
    localparam int unsigned DEF_ACK_TIMEOUT = 65535;
    localparam int unsigned DEF_GAP_CYCLES  = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_REQ  = 3'd2,
        ST_SEND = 3'd3,
        ST_GAP  = 3'd4
    } tx_state_e;

endpackage

// File: rtl/bt_sync_fifo.sv
// Single-clock FIFO with registered count/full/empty; head of queue is visible combinationally.
module bt_sync_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_head_c,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;

    assign w_push = i_wr_en & ~r_full;
    assign w_pop  = i_rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_head_c = r_mem[r_rd_ptr];
    assign o_count  = r_count;
    assign o_full   = r_full;
    assign o_empty  = r_empty;

endmodule

// File: rtl/bt_tx_queue.sv
// Byte queue plus transmit sequencer feeding the Bluetooth UART; paces bytes on the
// peripheral's busy handshake after synchronising it into this clock domain.
module bt_tx_queue
    import bt_pkg::*;
#(
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clear_err,
    output logic [7:0]        tx_din,
    output logic              tx_enable,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              timeout_err,
    output logic              idle
);

    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    tx_state_e        r_state;
    logic [7:0]       r_tx_din;
    logic             r_tx_enable;
    logic [TMR_W-1:0] r_timer;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_overflow;
    logic             r_timeout_err;
    logic             r_busy_m;
    logic             r_busy_s;
    logic             r_busy_s_d;
    logic             r_done_m;
    logic             r_done_s;

    logic [7:0]       w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_busy_fall;
    logic             w_timeout_hit;
    logic             w_unused_done;

    bt_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_fifo (
        .i_clk     (clk_in),
        .i_rst_n   (reset),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .i_rd_en   (w_pop),
        .o_head_c  (w_head),
        .o_count   (count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Two-flop synchronisers; done is carried across for visibility only.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_busy_m   <= 1'b0;
            r_busy_s   <= 1'b0;
            r_busy_s_d <= 1'b0;
            r_done_m   <= 1'b0;
            r_done_s   <= 1'b0;
        end else begin
            r_busy_m   <= tx_busy;
            r_busy_s   <= r_busy_m;
            r_busy_s_d <= r_busy_s;
            r_done_m   <= tx_done;
            r_done_s   <= r_done_m;
        end
    end

    assign w_unused_done = r_done_s;
    assign w_busy_fall   = r_busy_s_d & ~r_busy_s;
    assign w_pop         = (r_state == ST_LOAD);
    assign w_timeout_hit = (r_state == ST_REQ) & ~r_busy_s
                         & (r_timer == TMR_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_tx_din    <= 8'h00;
            r_tx_enable <= 1'b0;
            r_timer     <= '0;
            r_gap_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_empty) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_tx_din    <= w_head;
                    r_tx_enable <= 1'b1;
                    r_timer     <= '0;
                    r_state     <= ST_REQ;
                end
                ST_REQ: begin
                    if (r_busy_s) begin
                        r_tx_enable <= 1'b0;
                        r_state     <= ST_SEND;
                    end else if (w_timeout_hit) begin
                        // Unacknowledged byte is dropped; still observe the gap before retrying.
                        r_tx_enable <= 1'b0;
                        r_gap_cnt   <= '0;
                        r_state     <= ST_GAP;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_SEND: begin
                    if (w_busy_fall) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle beats clear_err.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (wr_en && w_full) r_overflow <= 1'b1;
            else if (clear_err)  r_overflow <= 1'b0;
            if (w_timeout_hit)   r_timeout_err <= 1'b1;
            else if (clear_err)  r_timeout_err <= 1'b0;
        end
    end

    assign tx_din      = r_tx_din;
    assign tx_enable   = r_tx_enable;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;
    assign full        = w_full;
    assign empty       = w_empty;
    assign idle        = (r_state == ST_IDLE) & w_empty;

endmodule

// File: tb/tb_bt_tx_queue.sv
// Randomised bench for bt_tx_queue: peripheral model, transaction-level queue model and directed scenarios.
module tb_bt_tx_queue;

    localparam int DEPTH = 16;
    localparam int ACK   = 8;
    localparam int GAP   = 4;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       clear_err;
    logic       full, empty, overflow, tx_enable, timeout_err, idle;
    logic [4:0] count;
    logic [7:0] tx_din;
    logic       tx_busy;
    logic       tx_done;

    logic per_en    = 1'b0;
    logic per_busy  = 1'b0;
    logic per_done  = 1'b0;
    logic hold_busy = 1'b0;
    int unsigned per_d, per_len;

    int n_checks  = 0;
    int n_errors  = 0;
    int en_pulses = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    int   m_count = 0;
    logic m_ov    = 1'b0;
    logic p_acc   = 1'b0;
    logic p_ovf   = 1'b0;
    logic p_clr   = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic prev_en = 1'b0;
    logic rise;

    assign tx_busy = per_busy | hold_busy;
    assign tx_done = per_done;

    always #5 clk_in = ~clk_in;

    bt_tx_queue #(
        .DEPTH       (DEPTH),
        .ADDR_W      (4),
        .ACK_TIMEOUT (ACK),
        .GAP_CYCLES  (GAP)
    ) u_dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .clear_err   (clear_err),
        .tx_din      (tx_din),
        .tx_enable   (tx_enable),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .timeout_err (timeout_err),
        .idle        (idle)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_en(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (tx_enable !== lvl && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(tx_enable), 32'(lvl));
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (tx_busy !== lvl && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(tx_busy), 32'(lvl));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (idle !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(idle), 1);
    endtask

    // Peripheral: acknowledges a request after a short random delay, stays busy for a frame.
    always begin
        @(negedge clk_in);
        if (per_en && tx_enable && reset) begin
            per_d   = $urandom_range(3, 1);
            per_len = $urandom_range(20, 5);
            repeat (per_d) @(negedge clk_in);
            #1 per_busy = 1'b1;
            repeat (per_len) @(negedge clk_in);
            #1 per_busy = 1'b0;
            per_done = 1'b1;
            @(negedge clk_in);
            #1 per_done = 1'b0;
        end
    end

    // Queue model: accepted writes enter, each request (enable rising) removes the head.
    always @(negedge clk_in) begin
        if (!reset) begin
            m_count = 0;
            m_ov    = 1'b0;
            p_acc   = 1'b0;
            p_ovf   = 1'b0;
            prev_en = 1'b0;
            exp_q.delete();
        end else begin
            rise = tx_enable && !prev_en;
            if (p_acc) exp_q.push_back(p_data);
            m_count = m_count + int'(p_acc) - int'(rise);
            if (p_ovf)      m_ov = 1'b1;
            else if (p_clr) m_ov = 1'b0;
            if (rise) begin
                en_pulses++;
                if (exp_q.size() == 0) check("sb_unexpected_req", 32'(tx_din), 32'hFFFF_FFFF);
                else                   check("sb_byte", 32'(tx_din), 32'(exp_q.pop_front()));
            end
            prev_en = tx_enable;
        end
        check("m_count", 32'(count), 32'(m_count));
        check("m_full", 32'(full), 32'(m_count == DEPTH));
        check("m_empty", 32'(empty), 32'(m_count == 0));
        check("m_overflow", 32'(overflow), 32'(m_ov));
        p_acc  = reset && wr_en && (m_count < DEPTH);
        p_ovf  = reset && wr_en && (m_count == DEPTH);
        p_clr  = clear_err;
        p_data = wr_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        clear_err = 1'b0;
        #3 reset  = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_enable", 32'(tx_enable), 0);
        check("rst_din", 32'(tx_din), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_empty", 32'(empty), 1);
        check("rst_count", 32'(count), 0);
        reset = 1'b1;
        repeat (2) tick();

        // Single byte: three-cycle request latency, handshake, gap before idle
        per_en = 1'b1;
        push(8'h41);
        check("sb_cnt1", 32'(count), 1);
        check("sb_en_t1", 32'(tx_enable), 0);
        tick();
        check("sb_en_t2", 32'(tx_enable), 0);
        tick();
        check("sb_en_t3", 32'(tx_enable), 1);
        check("sb_din", 32'(tx_din), 'h41);
        check("sb_cnt0", 32'(count), 0);
        wait_busy(1'b1, 50, "sb_busy_rise");
        check("sb_en_hold1", 32'(tx_enable), 1);
        tick();
        check("sb_en_hold2", 32'(tx_enable), 1);
        tick();
        check("sb_en_drop", 32'(tx_enable), 0);
        wait_busy(1'b0, 60, "sb_busy_fall");
        repeat (GAP) tick();
        check("sb_gap_not_idle", 32'(idle), 0);
        repeat (2) tick();
        check("sb_idle_back", 32'(idle), 1);
        check("sb_din_stable", 32'(tx_din), 'h41);

        // Burst ordering 01..05, one request per byte
        p0 = en_pulses;
        for (int i = 1; i <= 5; i++) push(8'(i));
        wait_idle(2000, "burst_idle");
        check("burst_pulses", 32'(en_pulses - p0), 5);
        check("burst_sb_drained", 32'(exp_q.size()), 0);

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            wr_en   = ($urandom_range(3, 0) == 0);
            wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        wait_idle(8000, "rand_idle");
        check("rand_sb_drained", 32'(exp_q.size()), 0);

        // Overflow with the peripheral stuck busy
        per_en = 1'b0;
        push(8'h80);
        wait_en(1'b1, 20, "ov_req");
        hold_busy = 1'b1;
        wait_en(1'b0, 20, "ov_send");
        for (int i = 0; i < DEPTH; i++) push(8'($urandom));
        check("ov_full", 32'(full), 1);
        check("ov_count16", 32'(count), 16);
        check("ov_not_yet", 32'(overflow), 0);
        push(8'h77);
        check("ov_set", 32'(overflow), 1);
        check("ov_count_kept", 32'(count), 16);
        wr_en     = 1'b1;
        clear_err = 1'b1;
        tick();
        wr_en     = 1'b0;
        clear_err = 1'b0;
        check("ov_error_wins", 32'(overflow), 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("ov_cleared", 32'(overflow), 0);
        hold_busy = 1'b0;
        per_en    = 1'b1;
        wait_idle(4000, "ov_drain_idle");
        check("ov_sb_drained", 32'(exp_q.size()), 0);

        // Write in the LOAD cycle with three bytes queued
        per_en = 1'b0;
        push(8'h90);
        wait_en(1'b1, 20, "pp_req");
        hold_busy = 1'b1;
        wait_en(1'b0, 20, "pp_send");
        push(8'h31);
        push(8'h32);
        push(8'h33);
        check("pp_count3", 32'(count), 3);
        hold_busy = 1'b0;
        per_en    = 1'b1;
        repeat (GAP + 4) tick();
        wr_en   = 1'b1;
        wr_data = 8'h34;
        tick();
        wr_en   = 1'b0;
        check("pp_req_after_load", 32'(tx_enable), 1);
        check("pp_count_same", 32'(count), 3);
        wait_idle(2000, "pp_idle");

        // Acknowledge timeout: AA is dropped, BB requested next
        per_en = 1'b0;
        push(8'hAA);
        push(8'hBB);
        wait_en(1'b1, 20, "to_req");
        check("to_din_aa", 32'(tx_din), 'hAA);
        check("to_no_err_yet", 32'(timeout_err), 0);
        n = 0;
        while (tx_enable && n < 100) begin
            n++;
            tick();
        end
        check("to_req_len", 32'(n), ACK);
        check("to_err_set", 32'(timeout_err), 1);
        wait_en(1'b1, 50, "to_req_bb");
        check("to_din_bb", 32'(tx_din), 'hBB);
        per_en    = 1'b1;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("to_err_cleared", 32'(timeout_err), 0);
        wait_idle(2000, "to_idle");

        // Asynchronous reset while requesting with four bytes queued
        per_en = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'(8'hC0 + i));
        wait_en(1'b1, 20, "ar_req");
        check("ar_count4", 32'(count), 4);
        #2 reset = 1'b0;
        #1;
        check("ar_en_drop", 32'(tx_enable), 0);
        check("ar_count0", 32'(count), 0);
        check("ar_empty", 32'(empty), 1);
        tick();
        reset = 1'b1;
        p0 = en_pulses;
        repeat (40) tick();
        check("ar_no_req", 32'(en_pulses - p0), 0);
        check("ar_idle", 32'(idle), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
